// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter
// Purpose  : Register-file writeback arbiter; load returns beat execute
//            results, with an in-order load-destination queue and busy lookup.
// Revision : 1.0
// ============================================================================
module wb_arbiter #(
  parameter int XLEN      = 64,
  parameter int LDQ_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic [4:0]      ex_rd,
  input  logic [XLEN-1:0] ex_data,
  output logic            ex_ready,
  input  logic            ld_issue,
  input  logic [4:0]      ld_issue_rd,
  input  logic            ld_valid,
  input  logic [XLEN-1:0] ld_data,
  output logic            ld_full,
  input  logic [4:0]      rs1_idx,
  input  logic [4:0]      rs2_idx,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            rf_wen,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_data,
  output logic            err
);

  localparam int PW = $clog2(LDQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(LDQ_DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [4:0]      mem_q [LDQ_DEPTH];
  logic [4:0]      mem_d [LDQ_DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            rf_wen_q, rf_wen_d;
  logic [4:0]      rf_rd_q, rf_rd_d;
  logic [XLEN-1:0] rf_data_q, rf_data_d;
  logic            err_q, err_d;

  logic            empty;
  logic            full;
  logic            pop;
  logic            push;
  logic [4:0]      head_rd;

  assign ex_ready = ~ld_valid;
  assign ld_full  = full;
  assign rf_wen   = rf_wen_q;
  assign rf_rd    = rf_rd_q;
  assign rf_data  = rf_data_q;
  assign err      = err_q;

  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == FULL_CNT);
    head_rd = mem_q[rd_ptr_q];
    // A pop frees a slot, so a full queue can still take a same-cycle issue.
    pop     = ld_valid & ~empty;
    push    = ld_issue & (~full | pop);

    mem_d     = mem_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    rf_wen_d  = 1'b0;
    rf_rd_d   = rf_rd_q;
    rf_data_d = rf_data_q;
    err_d     = err_q;

    if (rst) begin
      for (int i = 0; i < LDQ_DEPTH; i++) begin
        mem_d[i] = '0;
      end
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      count_d   = '0;
      rf_rd_d   = '0;
      rf_data_d = '0;
      err_d     = 1'b0;
    end else begin
      if (pop) begin
        rf_wen_d  = (head_rd != 5'd0);
        rf_rd_d   = head_rd;
        rf_data_d = ld_data;
        rd_ptr_d  = rd_ptr_q + PTR_ONE;
      end else if (ex_valid && ex_ready) begin
        rf_wen_d  = (ex_rd != 5'd0);
        rf_rd_d   = ex_rd;
        rf_data_d = ex_data;
      end

      if (push) begin
        mem_d[wr_ptr_q] = ld_issue_rd;
        wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end

      if (push && !pop) begin
        count_d = count_q + CNT_ONE;
      end else if (pop && !push) begin
        count_d = count_q - CNT_ONE;
      end

      if ((ld_valid && empty) || (ld_issue && full && !ld_valid)) begin
        err_d = 1'b1;
      end
    end
  end

  // Busy covers queued destinations plus the write currently landing in the RF.
  always_comb begin
    logic [PW-1:0] offs;
    logic          hit1;
    logic          hit2;
    hit1 = rf_wen_q && (rf_rd_q == rs1_idx);
    hit2 = rf_wen_q && (rf_rd_q == rs2_idx);
    offs = '0;
    for (int i = 0; i < LDQ_DEPTH; i++) begin
      offs = PW'(i) - rd_ptr_q;
      if ({1'b0, offs} < count_q) begin
        if (mem_q[i] == rs1_idx) hit1 = 1'b1;
        if (mem_q[i] == rs2_idx) hit2 = 1'b1;
      end
    end
    rs1_busy = hit1 && (rs1_idx != 5'd0);
    rs2_busy = hit2 && (rs2_idx != 5'd0);
  end

  always_ff @(posedge clk) begin
    mem_q     <= mem_d;
    rd_ptr_q  <= rd_ptr_d;
    wr_ptr_q  <= wr_ptr_d;
    count_q   <= count_d;
    rf_wen_q  <= rf_wen_d;
    rf_rd_q   <= rf_rd_d;
    rf_data_q <= rf_data_d;
    err_q     <= err_d;
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_arbiter
// Purpose  : Directed self-checking bench for wb_arbiter.
// Revision : 1.0
// ============================================================================
module tb_wb_arbiter;

  localparam int XLEN = 64;

  logic            clk;
  logic            rst;
  logic            ex_valid;
  logic [4:0]      ex_rd;
  logic [XLEN-1:0] ex_data;
  logic            ex_ready;
  logic            ld_issue;
  logic [4:0]      ld_issue_rd;
  logic            ld_valid;
  logic [XLEN-1:0] ld_data;
  logic            ld_full;
  logic [4:0]      rs1_idx;
  logic [4:0]      rs2_idx;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            rf_wen;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_data;
  logic            err;

  int total = 0;
  int bad   = 0;

  wb_arbiter #(.XLEN(XLEN), .LDQ_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_data(ex_data), .ex_ready(ex_ready),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_full(ld_full),
    .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_data(rf_data), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    ex_valid = 0; ex_rd = 0; ex_data = 0;
    ld_issue = 0; ld_issue_rd = 0; ld_valid = 0; ld_data = 0;
  endtask

  task automatic do_reset();
    idle(); rst = 1; tick(); rst = 0;
  endtask

  task automatic test_reset();
    idle(); rs1_idx = 0; rs2_idx = 0;
    rst = 1; ex_valid = 1; ex_rd = 5'd9; ex_data = 64'h77; ld_issue = 1; ld_issue_rd = 5'd3;
    tick();
    ld_valid = 1; ld_data = 64'h99; #1;
    total++; if (ex_ready !== 1'b0) begin bad++; $display("FAIL reset_ex_ready_ldv got=%b exp=0", ex_ready); end
    tick();
    rst = 0; idle(); #1;
    total++; if (rf_wen !== 1'b0) begin bad++; $display("FAIL reset_rf_wen got=%b exp=0", rf_wen); end
    total++; if (rf_rd !== 5'd0) begin bad++; $display("FAIL reset_rf_rd got=%0d exp=0", rf_rd); end
    total++; if (rf_data !== 64'h0) begin bad++; $display("FAIL reset_rf_data got=%0h exp=0", rf_data); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
    total++; if (ld_full !== 1'b0) begin bad++; $display("FAIL reset_ld_full got=%b exp=0", ld_full); end
    total++; if (ex_ready !== 1'b1) begin bad++; $display("FAIL reset_ex_ready got=%b exp=1", ex_ready); end
    rs1_idx = 5'd3; #1;
    total++; if (rs1_busy !== 1'b0) begin bad++; $display("FAIL reset_issue_ignored got=%b exp=0", rs1_busy); end
  endtask

  task automatic test_ex_write();
    do_reset();
    ex_valid = 1; ex_rd = 5'd5; ex_data = 64'h1234; #1;
    total++; if (ex_ready !== 1'b1) begin bad++; $display("FAIL ex_ready got=%b exp=1", ex_ready); end
    tick(); idle(); #1;
    total++; if (rf_wen !== 1'b1) begin bad++; $display("FAIL ex_wen got=%b exp=1", rf_wen); end
    total++; if (rf_rd !== 5'd5) begin bad++; $display("FAIL ex_rd got=%0d exp=5", rf_rd); end
    total++; if (rf_data !== 64'h1234) begin bad++; $display("FAIL ex_data got=%0h exp=1234", rf_data); end
    tick();
    total++; if (rf_wen !== 1'b0) begin bad++; $display("FAIL ex_wen_drop got=%b exp=0", rf_wen); end
    total++; if (rf_rd !== 5'd5 || rf_data !== 64'h1234) begin bad++; $display("FAIL ex_hold got=%0d/%0h exp=5/1234", rf_rd, rf_data); end
  endtask

  task automatic test_load_priority();
    do_reset();
    rs1_idx = 5'd7; rs2_idx = 5'd3;
    ld_issue = 1; ld_issue_rd = 5'd7; #1;
    total++; if (rs1_busy !== 1'b0) begin bad++; $display("FAIL ldp_busy_pre got=%b exp=0", rs1_busy); end
    tick(); idle();
    total++; if (rs1_busy !== 1'b1) begin bad++; $display("FAIL ldp_busy_q got=%b exp=1", rs1_busy); end
    ld_valid = 1; ld_data = 64'hAA; ex_valid = 1; ex_rd = 5'd3; ex_data = 64'h55; #1;
    total++; if (ex_ready !== 1'b0) begin bad++; $display("FAIL ldp_ex_ready got=%b exp=0", ex_ready); end
    tick(); idle(); #1;
    total++; if (rf_wen !== 1'b1 || rf_rd !== 5'd7 || rf_data !== 64'hAA) begin bad++; $display("FAIL ldp_write got=%b/%0d/%0h exp=1/7/aa", rf_wen, rf_rd, rf_data); end
    total++; if (rs1_busy !== 1'b1) begin bad++; $display("FAIL ldp_busy_flight got=%b exp=1", rs1_busy); end
    total++; if (rs2_busy !== 1'b0) begin bad++; $display("FAIL ldp_busy_rs2 got=%b exp=0", rs2_busy); end
    tick();
    total++; if (rs1_busy !== 1'b0) begin bad++; $display("FAIL ldp_busy_clear got=%b exp=0", rs1_busy); end
    total++; if (rf_wen !== 1'b0 || rf_rd !== 5'd7) begin bad++; $display("FAIL ldp_ex_dropped got=%b/%0d exp=0/7", rf_wen, rf_rd); end
  endtask

  task automatic test_full_drop();
    do_reset();
    rs1_idx = 5'd1; rs2_idx = 5'd4;
    ld_issue = 1; ld_issue_rd = 5'd1; tick();
    ld_issue_rd = 5'd2; tick();
    total++; if (ld_full !== 1'b1) begin bad++; $display("FAIL fd_full got=%b exp=1", ld_full); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL fd_err_pre got=%b exp=0", err); end
    ld_issue_rd = 5'd4; tick(); idle();
    total++; if (err !== 1'b1) begin bad++; $display("FAIL fd_err got=%b exp=1", err); end
    total++; if (rs2_busy !== 1'b0) begin bad++; $display("FAIL fd_not_queued got=%b exp=0", rs2_busy); end
    ld_valid = 1; ld_data = 64'h11; tick();
    total++; if (rf_wen !== 1'b1 || rf_rd !== 5'd1 || rf_data !== 64'h11) begin bad++; $display("FAIL fd_first got=%b/%0d/%0h exp=1/1/11", rf_wen, rf_rd, rf_data); end
    total++; if (ld_full !== 1'b0) begin bad++; $display("FAIL fd_not_full got=%b exp=0", ld_full); end
    ld_data = 64'h22; tick(); idle();
    total++; if (rf_wen !== 1'b1 || rf_rd !== 5'd2 || rf_data !== 64'h22) begin bad++; $display("FAIL fd_second got=%b/%0d/%0h exp=1/2/22", rf_wen, rf_rd, rf_data); end
    tick();
    total++; if (err !== 1'b1) begin bad++; $display("FAIL fd_err_sticky got=%b exp=1", err); end
  endtask

  task automatic test_full_swap();
    do_reset();
    rs1_idx = 5'd9; rs2_idx = 5'd2;
    ld_issue = 1; ld_issue_rd = 5'd1; tick();
    ld_issue_rd = 5'd2; tick();
    ld_issue_rd = 5'd9; ld_valid = 1; ld_data = 64'h33; tick(); idle();
    total++; if (rf_wen !== 1'b1 || rf_rd !== 5'd1 || rf_data !== 64'h33) begin bad++; $display("FAIL fs_head got=%b/%0d/%0h exp=1/1/33", rf_wen, rf_rd, rf_data); end
    total++; if (ld_full !== 1'b1) begin bad++; $display("FAIL fs_full got=%b exp=1", ld_full); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL fs_err got=%b exp=0", err); end
    total++; if (rs1_busy !== 1'b1) begin bad++; $display("FAIL fs_rd9_queued got=%b exp=1", rs1_busy); end
    ld_valid = 1; ld_data = 64'h44; tick();
    total++; if (rf_rd !== 5'd2 || rf_data !== 64'h44) begin bad++; $display("FAIL fs_pop2 got=%0d/%0h exp=2/44", rf_rd, rf_data); end
    ld_data = 64'h66; tick(); idle();
    total++; if (rf_rd !== 5'd9 || rf_data !== 64'h66) begin bad++; $display("FAIL fs_pop9 got=%0d/%0h exp=9/66", rf_rd, rf_data); end
    tick();
    total++; if (rs1_busy !== 1'b0 || ld_full !== 1'b0) begin bad++; $display("FAIL fs_drained got=%b/%b exp=0/0", rs1_busy, ld_full); end
  endtask

  task automatic test_empty_and_x0();
    do_reset();
    rs1_idx = 5'd0; rs2_idx = 5'd8;
    ld_valid = 1; ld_data = 64'hDEAD; tick(); idle();
    total++; if (rf_wen !== 1'b0) begin bad++; $display("FAIL em_wen got=%b exp=0", rf_wen); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL em_err got=%b exp=1", err); end
    ex_valid = 1; ex_rd = 5'd0; ex_data = 64'hBEEF; tick(); idle();
    total++; if (rf_wen !== 1'b0) begin bad++; $display("FAIL x0_ex_wen got=%b exp=0", rf_wen); end
    ld_issue = 1; ld_issue_rd = 5'd0; tick();
    ld_issue_rd = 5'd8; tick(); idle();
    total++; if (ld_full !== 1'b1 || rs1_busy !== 1'b0) begin bad++; $display("FAIL x0_queued got=%b/%b exp=1/0", ld_full, rs1_busy); end
    // WAW: execute write to x8 lands while the x8 load is still queued.
    ex_valid = 1; ex_rd = 5'd8; ex_data = 64'h88; tick(); idle();
    total++; if (rf_wen !== 1'b1 || rf_rd !== 5'd8 || rf_data !== 64'h88) begin bad++; $display("FAIL waw_write got=%b/%0d/%0h exp=1/8/88", rf_wen, rf_rd, rf_data); end
    tick();
    total++; if (rs2_busy !== 1'b1) begin bad++; $display("FAIL waw_busy got=%b exp=1", rs2_busy); end
    ld_valid = 1; ld_data = 64'h70; tick();
    total++; if (rf_wen !== 1'b0 || ld_full !== 1'b0) begin bad++; $display("FAIL x0_pop got=%b/%b exp=0/0", rf_wen, ld_full); end
    ld_data = 64'h71; tick(); idle();
    total++; if (rf_wen !== 1'b1 || rf_rd !== 5'd8 || rf_data !== 64'h71) begin bad++; $display("FAIL waw_drain got=%b/%0d/%0h exp=1/8/71", rf_wen, rf_rd, rf_data); end
    tick();
    total++; if (rs2_busy !== 1'b0) begin bad++; $display("FAIL waw_clear got=%b exp=0", rs2_busy); end
  endtask

  task automatic test_reset_mid();
    rs1_idx = 5'd5; rs2_idx = 5'd6;
    ld_issue = 1; ld_issue_rd = 5'd5; tick();
    ld_issue_rd = 5'd6; tick(); idle();
    total++; if (rs1_busy !== 1'b1 || rs2_busy !== 1'b1 || ld_full !== 1'b1) begin bad++; $display("FAIL rm_pre got=%b/%b/%b exp=1/1/1", rs1_busy, rs2_busy, ld_full); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL rm_err_pre got=%b exp=1", err); end
    rst = 1; ld_valid = 1; ld_data = 64'h5; ld_issue = 1; ld_issue_rd = 5'd6; ex_valid = 1; ex_rd = 5'd5;
    tick(); rst = 0; idle(); #1;
    total++; if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin bad++; $display("FAIL rm_busy got=%b/%b exp=0/0", rs1_busy, rs2_busy); end
    total++; if (ld_full !== 1'b0 || err !== 1'b0 || rf_wen !== 1'b0) begin bad++; $display("FAIL rm_state got=%b/%b/%b exp=0/0/0", ld_full, err, rf_wen); end
  endtask

  initial begin
    rst = 1; rs1_idx = 0; rs2_idx = 0; idle();
    tick();
    test_reset();
    test_ex_write();
    test_load_priority();
    test_full_drop();
    test_full_swap();
    test_empty_and_x0();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
